// File: rtl/uart_tx_frame_ctrl_pkg.sv
// uart_tx_frame_ctrl_pkg: shared UART frame constants, FSM encoding and frame builder
package uart_tx_frame_ctrl_pkg;
    localparam int UART_FRAME_BITS = 11;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT = 1'b1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
    function automatic logic [UART_FRAME_BITS-1:0] build_frame(input logic [7:0] d, input logic odd);
        return {UART_STOP_BIT, ^d ^ odd, d, UART_START_BIT};
    endfunction
endpackage

// File: rtl/uart_tx_frame_ctrl_baud.sv
// uart_baud_tick: bit-period counter with clear and terminal-count tick
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick_o = en_i && (cnt_q == LAST);
    // Count while enabled, wrapping on the tick; clear dominates
    always_comb cnt_d = clr_i ? '0 : !en_i ? cnt_q : tick_o ? '0 : cnt_q + 1'b1;
    // Counter register
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl: builds the UART frame and paces load/shift pulses for the TX shifter
module uart_tx_frame_ctrl
    import uart_tx_frame_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 data,
    output logic                       load,
    output logic                       shift,
    output logic [UART_FRAME_BITS-1:0] frame,
    output logic                       busy,
    output logic                       done
);
    localparam int BIT_W = $clog2(UART_FRAME_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_FRAME_BITS - 1);
    logic [1:0] state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [UART_FRAME_BITS-1:0] frame_q, frame_d;
    logic tick;
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != ST_SEND),
        .en_i   (state_q == ST_SEND),
        .tick_o (tick)
    );
    assign load  = state_q == ST_LOAD;
    assign shift = tick;
    assign busy  = (state_q == ST_LOAD) || (state_q == ST_SEND);
    assign done  = state_q == ST_DONE;
    assign frame = frame_q;
    // Next-state logic; the frame register captures the byte at accept so it is valid during LOAD
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        unique case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_LOAD;
                frame_d = build_frame(data, PARITY_ODD);
            end
            ST_LOAD: begin
                bit_cnt_d = '0;
                state_d   = ST_SEND;
            end
            ST_SEND: if (tick) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                state_d   = (bit_cnt_q == LAST_BIT) ? ST_DONE : ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            frame_q   <= '1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb_uart_tx_frame_ctrl: randomized and directed checks against a serial line model
module tb_uart_tx_frame_ctrl;
    localparam int CPB = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [7:0] data = 8'h00;
    logic ld [2];
    logic sf [2];
    logic bz [2];
    logic dn [2];
    logic [10:0] fr [2];
    int n_cmp = 0;
    int n_err = 0;
    int overlap = 0;
    int done_seen = 0;
    logic [10:0] sh [2];
    logic [10:0] acc [2];
    int nb [2];
    logic [10:0] rx0 [$];
    logic [10:0] rx1 [$];

    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .rst(rst), .start(start), .data(data),
        .load(ld[0]), .shift(sf[0]), .frame(fr[0]), .busy(bz[0]), .done(dn[0])
    );
    uart_tx_frame_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .start(start), .data(data),
        .load(ld[1]), .shift(sf[1]), .frame(fr[1]), .busy(bz[1]), .done(dn[1])
    );

    // Shifter model: parallel load, then each shift ends the current line bit
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ld[i] && sf[i]) overlap++;
            if (dn[i]) done_seen++;
            if (rst) begin
                sh[i] = '1;
                nb[i] = 0;
            end else if (ld[i]) begin
                sh[i] = fr[i];
            end else if (sf[i]) begin
                acc[i][nb[i]] = sh[i][0];
                sh[i] = {1'b1, sh[i][10:1]};
                nb[i]++;
                if (nb[i] == 11) begin
                    if (i == 0) rx0.push_back(acc[i]);
                    else rx1.push_back(acc[i]);
                    nb[i] = 0;
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({ld[0], sf[0], bz[0], dn[0]} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0000", {ld[0], sf[0], bz[0], dn[0]});
        end
        n_cmp++;
        if (fr[0] !== 11'h7FF) begin
            n_err++;
            $display("FAIL reset_frame: got %h want 7ff", fr[0]);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (fr[0] !== 11'h7FF || bz[0] !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: frame %h busy %b want 7ff 0", fr[0], bz[0]);
        end
    endtask

    task automatic test_frame_even;
        logic [3:0] exp, got;
        rx0.delete();
        rx1.delete();
        data = 8'hA5;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 47; c++) begin
            exp = {c == 1, c >= 5 && c <= 45 && (c - 1) % CPB == 0, c >= 1 && c <= 45, c == 46};
            got = {ld[0], sf[0], bz[0], dn[0]};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL timing cycle %0d load/shift/busy/done: got %b want %b", c, got, exp);
            end
            if (c == 1) begin
                n_cmp++;
                if (fr[0] !== 11'h54A) begin
                    n_err++;
                    $display("FAIL even_frame: got %h want 54a", fr[0]);
                end
            end
            step();
        end
        n_cmp++;
        if (rx0.size() != 1 || rx0[0] !== 11'b10101001010) begin
            n_err++;
            $display("FAIL even_line: got %0d frames first %b want 1 frame 10101001010", rx0.size(), rx0.size() ? rx0[0] : 11'h0);
        end
    endtask

    task automatic test_parity_odd;
        rx0.delete();
        rx1.delete();
        data = 8'hA5;
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if (fr[1] !== 11'h74A) begin
            n_err++;
            $display("FAIL odd_frame: got %h want 74a", fr[1]);
        end
        repeat (47) step();
        n_cmp++;
        if (rx1.size() != 1 || rx1[0] !== 11'h74A) begin
            n_err++;
            $display("FAIL odd_line: got %0d frames first %h want 1 frame 74a", rx1.size(), rx1.size() ? rx1[0] : 11'h0);
        end
        n_cmp++;
        if (rx1.size() != 1 || rx1[0][9] !== 1'b1) begin
            n_err++;
            $display("FAIL odd_parity_bit: got %b want 1", rx1.size() ? rx1[0][9] : 1'bx);
        end
    endtask

    task automatic test_busy_ignore;
        int shifts = 0;
        int dn_cyc = -1;
        int frame_bad = 0;
        rx0.delete();
        rx1.delete();
        data = 8'hA5;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            if (c == 10) begin
                data = 8'h3C;
                start = 1'b1;
            end else if (c == 11) start = 1'b0;
            if (sf[0]) shifts++;
            if (dn[0]) dn_cyc = c;
            if (fr[0] !== 11'h54A) frame_bad++;
            step();
        end
        n_cmp++;
        if (shifts != 11) begin
            n_err++;
            $display("FAIL ignore_shift_count: got %0d want 11", shifts);
        end
        n_cmp++;
        if (dn_cyc != 46) begin
            n_err++;
            $display("FAIL ignore_done_cycle: got %0d want 46", dn_cyc);
        end
        n_cmp++;
        if (frame_bad != 0) begin
            n_err++;
            $display("FAIL ignore_frame_stable: got %0d changed cycles want 0", frame_bad);
        end
        n_cmp++;
        if (rx0.size() != 1 || rx0[0] !== 11'h54A) begin
            n_err++;
            $display("FAIL ignore_line: got %0d frames want 1 frame 54a", rx0.size());
        end
    endtask

    task automatic test_back_to_back;
        int c = 0;
        int last_done = -100;
        int nd = 0;
        int nl = 0;
        int extra = 0;
        rx0.delete();
        rx1.delete();
        data = 8'h00;
        start = 1'b1;
        while (nd < 3 && c < 300) begin
            step();
            c++;
            if (ld[0]) begin
                n_cmp++;
                if (c != (nl == 0 ? 1 : last_done + 2)) begin
                    n_err++;
                    $display("FAIL b2b_load_cycle: got %0d want %0d", c, nl == 0 ? 1 : last_done + 2);
                end
                n_cmp++;
                if (fr[0] !== 11'h400) begin
                    n_err++;
                    $display("FAIL b2b_frame: got %h want 400", fr[0]);
                end
                nl++;
            end
            if (dn[0]) begin
                last_done = c;
                nd++;
                if (nd == 3) start = 1'b0;
            end
        end
        n_cmp++;
        if (nd != 3) begin
            n_err++;
            $display("FAIL b2b_timeout: got %0d done pulses want 3", nd);
        end
        repeat (10) begin
            step();
            if (ld[0]) extra++;
        end
        n_cmp++;
        if (extra != 0 || rx0.size() != 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d extra loads %0d frames want 0 and 3", extra, rx0.size());
        end
        foreach (rx0[k]) begin
            n_cmp++;
            if (rx0[k] !== 11'h400) begin
                n_err++;
                $display("FAIL b2b_line: got %h want 400", rx0[k]);
            end
        end
    endtask

    task automatic test_reset_mid;
        rx0.delete();
        rx1.delete();
        data = 8'h5A;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        n_cmp++;
        if (bz[0] !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy: got %b want 1", bz[0]);
        end
        done_seen = 0;
        rst = 1'b1;
        step();
        n_cmp++;
        if ({ld[0], sf[0], bz[0], dn[0]} !== 4'b0000 || fr[0] !== 11'h7FF) begin
            n_err++;
            $display("FAIL mid_reset: got %b frame %h want 0000 frame 7ff", {ld[0], sf[0], bz[0], dn[0]}, fr[0]);
        end
        rst = 1'b0;
        repeat (50) step();
        n_cmp++;
        if (done_seen != 0 || rx0.size() != 0 || bz[0] !== 1'b0) begin
            n_err++;
            $display("FAIL mid_no_done: got done %0d frames %0d busy %b want 0 0 0", done_seen, rx0.size(), bz[0]);
        end
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic [10:0] got;
        int bound;
        rx0.delete();
        rx1.delete();
        for (int n = 0; n < 1000; n++) begin
            b = 8'($urandom);
            data = b;
            start = 1'b1;
            step();
            start = 1'b0;
            data = 8'($urandom);
            bound = 0;
            while (!dn[0] && bound < 60) begin
                step();
                bound++;
            end
            n_cmp++;
            if (bound >= 60) begin
                n_err++;
                $display("FAIL rand_timeout: byte %h no done within 60 cycles", b);
            end
            got = rx0.size() ? rx0.pop_front() : 11'h0;
            n_cmp++;
            if (got[0] !== 1'b0 || got[10] !== 1'b1 || got[8:1] !== b || got[9] !== ^b) begin
                n_err++;
                $display("FAIL rand_even byte %0d: got frame %h want byte %h parity %b", n, got, b, ^b);
            end
            got = rx1.size() ? rx1.pop_front() : 11'h0;
            n_cmp++;
            if (got[0] !== 1'b0 || got[10] !== 1'b1 || got[8:1] !== b || got[9] !== ~^b) begin
                n_err++;
                $display("FAIL rand_odd byte %0d: got frame %h want byte %h parity %b", n, got, b, ~^b);
            end
            step();
            repeat ($urandom_range(0, 3)) step();
        end
        n_cmp++;
        if (overlap != 0) begin
            n_err++;
            $display("FAIL load_shift_overlap: got %0d cycles want 0", overlap);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_even();
        test_parity_odd();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
